// File: rtl/ball_pkg.sv
// Shared ball/field definitions: FSM state, field geometry and the saturating
// arithmetic helpers used by the ball integrator.
package ball_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLY    = 2'd1,
        COOL   = 2'd2,
        LANDED = 2'd3
    } ball_state_e;

    localparam int X_MIN      = 20;
    localparam int X_MAX      = 620;
    localparam int Y_GROUND   = 440;
    localparam int NET_X      = 320;
    localparam int NET_HALF_W = 8;
    localparam int NET_TOP    = 300;
    localparam int SERVE_X_L  = 120;
    localparam int SERVE_X_R  = 520;
    localparam int SERVE_Y    = 100;

    localparam int POS_W  = 11;
    localparam int VEL_W  = 10;
    localparam int CALC_W = 12;
    localparam int CNT_W  = 8;

    localparam logic signed [CALC_W-1:0] POS_HI = 12'sd1023;
    localparam logic signed [CALC_W-1:0] POS_LO = -12'sd1024;

    function automatic logic signed [CALC_W-1:0] sat12(
        input logic signed [CALC_W-1:0] v,
        input logic signed [CALC_W-1:0] lim
    );
        logic signed [CALC_W-1:0] r;
        r = v;
        if (v > lim) begin
            r = lim;
        end else if (v < -lim) begin
            r = -lim;
        end
        return r;
    endfunction

    function automatic logic signed [VEL_W-1:0] sat_vel(
        input logic signed [CALC_W-1:0] v,
        input logic signed [CALC_W-1:0] lim
    );
        logic signed [CALC_W-1:0] r;
        r = sat12(v, lim);
        return r[VEL_W-1:0];
    endfunction

    function automatic logic signed [POS_W-1:0] clamp_pos(
        input logic signed [CALC_W-1:0] v
    );
        logic signed [CALC_W-1:0] r;
        r = v;
        if (v > POS_HI) begin
            r = POS_HI;
        end else if (v < POS_LO) begin
            r = POS_LO;
        end
        return r[POS_W-1:0];
    endfunction

    function automatic logic signed [CALC_W-1:0] abs12(
        input logic signed [CALC_W-1:0] v
    );
        return (v < 0) ? -v : v;
    endfunction

endpackage

// File: rtl/ball_motion_if.sv
// Collision-to-ball handshake: a proposed velocity qualified by hit_valid.
interface ball_motion_if;
    import ball_pkg::*;

    logic signed [VEL_W-1:0] hit_v_x;
    logic signed [VEL_W-1:0] hit_v_y;
    logic                    hit_valid;

    modport master (output hit_v_x, hit_v_y, hit_valid);
    modport slave  (input  hit_v_x, hit_v_y, hit_valid);
endinterface

// File: rtl/ball_step.sv
// One frame of ball physics: gravity, integration, then wall/ceiling/net and
// finally ground resolution. Purely combinational.
module ball_step
    import ball_pkg::*;
#(
    parameter int X_MIN      = ball_pkg::X_MIN,
    parameter int X_MAX      = ball_pkg::X_MAX,
    parameter int Y_GROUND   = ball_pkg::Y_GROUND,
    parameter int NET_X      = ball_pkg::NET_X,
    parameter int NET_HALF_W = ball_pkg::NET_HALF_W,
    parameter int NET_TOP    = ball_pkg::NET_TOP,
    parameter int GRAVITY    = 2,
    parameter int V_SHIFT    = 3,
    parameter int V_MAX      = 200
) (
    input  logic signed [POS_W-1:0] pos_x,
    input  logic signed [POS_W-1:0] pos_y,
    input  logic signed [VEL_W-1:0] v_x,
    input  logic signed [VEL_W-1:0] v_y,
    output logic signed [POS_W-1:0] new_x,
    output logic signed [POS_W-1:0] new_y,
    output logic signed [VEL_W-1:0] new_v_x,
    output logic signed [VEL_W-1:0] new_v_y,
    output logic                    landed,
    output logic                    side
);

    localparam logic signed [CALC_W-1:0] G12     = 12'(GRAVITY);
    localparam logic signed [CALC_W-1:0] VMAX12  = 12'(V_MAX);
    localparam logic signed [CALC_W-1:0] XMIN12  = 12'(X_MIN);
    localparam logic signed [CALC_W-1:0] XMAX12  = 12'(X_MAX);
    localparam logic signed [CALC_W-1:0] YGND12  = 12'(Y_GROUND);
    localparam logic signed [CALC_W-1:0] NETX12  = 12'(NET_X);
    localparam logic signed [CALC_W-1:0] NETL12  = 12'(NET_X - NET_HALF_W);
    localparam logic signed [CALC_W-1:0] NETR12  = 12'(NET_X + NET_HALF_W);
    localparam logic signed [CALC_W-1:0] NETT12  = 12'(NET_TOP);

    logic signed [CALC_W-1:0] x0, y0, vx0, vy0, vy_g;
    logic signed [CALC_W-1:0] x1, y1, vx1, vy1;

    always_comb begin
        x0   = {pos_x[POS_W-1], pos_x};
        y0   = {pos_y[POS_W-1], pos_y};
        vx0  = {{2{v_x[VEL_W-1]}}, v_x};
        vy0  = {{2{v_y[VEL_W-1]}}, v_y};
        vy_g = sat12(vy0 + G12, VMAX12);

        // >>> on a signed operand floors, so small negative speeds still move
        vx1 = vx0;
        vy1 = vy_g;
        x1  = x0 + (vx0 >>> V_SHIFT);
        y1  = y0 + (vy_g >>> V_SHIFT);
        landed = 1'b0;

        if (x1 < XMIN12) begin
            x1  = XMIN12;
            vx1 = abs12(vx1);
        end else if (x1 > XMAX12) begin
            x1  = XMAX12;
            vx1 = -abs12(vx1);
        end

        if (y1 < 0) begin
            y1  = '0;
            vy1 = abs12(vy1);
        end

        // Net pushes the ball back to whichever side it came from
        if (y1 >= NETT12 && x1 >= NETL12 && x1 <= NETR12) begin
            if (x0 < NETX12) begin
                x1  = NETL12 - 12'sd1;
                vx1 = -abs12(vx1);
            end else begin
                x1  = NETR12 + 12'sd1;
                vx1 = abs12(vx1);
            end
        end

        if (y1 >= YGND12) begin
            y1     = YGND12;
            vx1    = '0;
            vy1    = '0;
            landed = 1'b1;
        end

        side    = (x1 >= NETX12);
        new_x   = clamp_pos(x1);
        new_y   = clamp_pos(y1);
        new_v_x = sat_vel(vx1, VMAX12);
        new_v_y = sat_vel(vy1, VMAX12);
    end

endmodule

// File: rtl/ball_motion.sv
// Ball state owner: rally FSM, hit cooldown / landing hold counter and the
// registered position and velocity fed to collision and rendering.
module ball_motion
    import ball_pkg::*;
#(
    parameter int X_MIN      = ball_pkg::X_MIN,
    parameter int X_MAX      = ball_pkg::X_MAX,
    parameter int Y_GROUND   = ball_pkg::Y_GROUND,
    parameter int NET_X      = ball_pkg::NET_X,
    parameter int NET_HALF_W = ball_pkg::NET_HALF_W,
    parameter int NET_TOP    = ball_pkg::NET_TOP,
    parameter int GRAVITY    = 2,
    parameter int V_SHIFT    = 3,
    parameter int V_MAX      = 200,
    parameter int COOLDOWN   = 8,
    parameter int LAND_HOLD  = 60,
    parameter int SERVE_X_L  = ball_pkg::SERVE_X_L,
    parameter int SERVE_X_R  = ball_pkg::SERVE_X_R,
    parameter int SERVE_Y    = ball_pkg::SERVE_Y
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    tick,
    input  logic                    serve,
    input  logic                    serve_side,
    ball_motion_if.slave            hit,
    output logic signed [POS_W-1:0] ball_pos_x,
    output logic signed [POS_W-1:0] ball_pos_y,
    output logic signed [VEL_W-1:0] ball_v_x,
    output logic signed [VEL_W-1:0] ball_v_y,
    output logic                    in_play,
    output logic                    land_pulse,
    output logic                    land_side
);

    localparam logic signed [POS_W-1:0]  SXL    = 11'(SERVE_X_L);
    localparam logic signed [POS_W-1:0]  SXR    = 11'(SERVE_X_R);
    localparam logic signed [POS_W-1:0]  SY     = 11'(SERVE_Y);
    localparam logic signed [CALC_W-1:0] VMAX12 = 12'(V_MAX);
    localparam logic [CNT_W-1:0]         COOL_LD = CNT_W'(COOLDOWN);
    localparam logic [CNT_W-1:0]         HOLD_LD = CNT_W'(LAND_HOLD);

    ball_state_e state_q, state_d;
    logic signed [POS_W-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic signed [VEL_W-1:0] v_x_q, v_x_d, v_y_q, v_y_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic in_play_q, in_play_d, land_pulse_q, land_pulse_d, land_side_q, land_side_d;

    logic signed [POS_W-1:0] step_x, step_y;
    logic signed [VEL_W-1:0] step_vx, step_vy;
    logic                    step_landed, step_side, do_step;
    logic signed [CALC_W-1:0] hit_vx12, hit_vy12;

    ball_step #(
        .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_GROUND(Y_GROUND), .NET_X(NET_X),
        .NET_HALF_W(NET_HALF_W), .NET_TOP(NET_TOP), .GRAVITY(GRAVITY),
        .V_SHIFT(V_SHIFT), .V_MAX(V_MAX)
    ) u_step (
        .pos_x(pos_x_q), .pos_y(pos_y_q), .v_x(v_x_q), .v_y(v_y_q),
        .new_x(step_x), .new_y(step_y), .new_v_x(step_vx), .new_v_y(step_vy),
        .landed(step_landed), .side(step_side)
    );

    always_comb begin
        state_d      = state_q;
        pos_x_d      = pos_x_q;
        pos_y_d      = pos_y_q;
        v_x_d        = v_x_q;
        v_y_d        = v_y_q;
        cnt_d        = cnt_q;
        land_side_d  = land_side_q;
        land_pulse_d = 1'b0;
        hit_vx12     = {{2{hit.hit_v_x[VEL_W-1]}}, hit.hit_v_x};
        hit_vy12     = {{2{hit.hit_v_y[VEL_W-1]}}, hit.hit_v_y};
        // A hit in FLY pre-empts the tick of the same cycle
        do_step      = tick && ((state_q == FLY && !hit.hit_valid) || state_q == COOL);

        case (state_q)
            IDLE: begin
                if (serve) begin
                    state_d = FLY;
                    pos_x_d = serve_side ? SXR : SXL;
                    pos_y_d = SY;
                    v_x_d   = '0;
                    v_y_d   = '0;
                end
            end
            FLY: begin
                if (hit.hit_valid) begin
                    state_d = COOL;
                    v_x_d   = sat_vel(hit_vx12, VMAX12);
                    v_y_d   = sat_vel(hit_vy12, VMAX12);
                    cnt_d   = COOL_LD;
                end
            end
            COOL: begin
                if (tick) begin
                    if (cnt_q <= 1) begin
                        state_d = FLY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            LANDED: begin
                if (tick) begin
                    if (cnt_q <= 1) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_step) begin
            pos_x_d = step_x;
            pos_y_d = step_y;
            v_x_d   = step_vx;
            v_y_d   = step_vy;
            if (step_landed) begin
                state_d      = LANDED;
                cnt_d        = HOLD_LD;
                land_pulse_d = 1'b1;
                land_side_d  = step_side;
            end
        end

        in_play_d = (state_d == FLY) || (state_d == COOL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pos_x_q      <= SXL;
            pos_y_q      <= SY;
            v_x_q        <= '0;
            v_y_q        <= '0;
            cnt_q        <= '0;
            in_play_q    <= 1'b0;
            land_pulse_q <= 1'b0;
            land_side_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pos_x_q      <= pos_x_d;
            pos_y_q      <= pos_y_d;
            v_x_q        <= v_x_d;
            v_y_q        <= v_y_d;
            cnt_q        <= cnt_d;
            in_play_q    <= in_play_d;
            land_pulse_q <= land_pulse_d;
            land_side_q  <= land_side_d;
        end
    end

    assign ball_pos_x = pos_x_q;
    assign ball_pos_y = pos_y_q;
    assign ball_v_x   = v_x_q;
    assign ball_v_y   = v_y_q;
    assign in_play    = in_play_q;
    assign land_pulse = land_pulse_q;
    assign land_side  = land_side_q;

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench: table of single-step physics vectors on ball_step, then
// hand-written rally sequences on ball_motion.
module tb_ball_motion;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tick = 1'b0;
    logic serve = 1'b0;
    logic serve_side = 1'b0;
    logic signed [10:0] ball_pos_x, ball_pos_y;
    logic signed [9:0]  ball_v_x, ball_v_y;
    logic in_play, land_pulse, land_side;

    ball_motion_if hit_if();

    ball_motion dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .serve(serve), .serve_side(serve_side),
        .hit(hit_if),
        .ball_pos_x(ball_pos_x), .ball_pos_y(ball_pos_y),
        .ball_v_x(ball_v_x), .ball_v_y(ball_v_y),
        .in_play(in_play), .land_pulse(land_pulse), .land_side(land_side)
    );

    logic signed [10:0] s_x, s_y, s_nx, s_ny;
    logic signed [9:0]  s_vx, s_vy, s_nvx, s_nvy;
    logic s_land, s_side;

    ball_step u_step (
        .pos_x(s_x), .pos_y(s_y), .v_x(s_vx), .v_y(s_vy),
        .new_x(s_nx), .new_y(s_ny), .new_v_x(s_nvx), .new_v_y(s_nvy),
        .landed(s_land), .side(s_side)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x, y, vx, vy;
        int ex, ey, evx, evy, eland, eside;
    } vec_t;

    vec_t vecs[13];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        tick = 1'b1;
        repeat (n) cyc();
        tick = 1'b0;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " x"}, ball_pos_x, 120);
        check({tag, " y"}, ball_pos_y, 100);
        check({tag, " vx"}, ball_v_x, 0);
        check({tag, " vy"}, ball_v_y, 0);
        check({tag, " in_play"}, in_play, 0);
        check({tag, " land_pulse"}, land_pulse, 0);
        check({tag, " land_side"}, land_side, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev_vx, ncap, cap0, cap1, found;
        hit_if.hit_valid = 1'b0;
        hit_if.hit_v_x   = '0;
        hit_if.hit_v_y   = '0;

        //          x    y    vx    vy    ex   ey   evx   evy  land side
        vecs[0]  = '{120, 100,   0,    0, 120, 100,    0,    2, 0, 0};
        vecs[1]  = '{615, 200,  80,    0, 620, 200,  -80,    2, 0, 0};
        vecs[2]  = '{ 25, 200, -80,    0,  20, 200,   80,    2, 0, 0};
        vecs[3]  = '{100,   5,   0, -100, 100,   0,    0,   98, 0, 0};
        vecs[4]  = '{310, 320,  40,    0, 311, 320,  -40,    2, 0, 0};
        vecs[5]  = '{330, 320, -40,    0, 329, 320,   40,    2, 0, 0};
        vecs[6]  = '{310, 200,  40,    0, 315, 200,   40,    2, 0, 0};
        vecs[7]  = '{500, 438,   0,   40, 500, 440,    0,    0, 1, 1};
        vecs[8]  = '{100, 438,  10,   40, 101, 440,    0,    0, 1, 0};
        vecs[9]  = '{100, 100,   0,  199, 100, 125,    0,  200, 0, 0};
        vecs[10] = '{100, 100,  -1,  -10,  99,  99,   -1,   -8, 0, 0};
        vecs[11] = '{100, 300, 200, -200, 125, 275,  200, -198, 0, 0};
        vecs[12] = '{310, 435,  40,   40, 311, 440,    0,    0, 1, 0};

        #12;
        rst_n = 1'b1;
        #1;
        check_reset_vals("reset");

        for (int i = 0; i < 13; i++) begin
            s_x  = 11'(vecs[i].x);
            s_y  = 11'(vecs[i].y);
            s_vx = 10'(vecs[i].vx);
            s_vy = 10'(vecs[i].vy);
            #1;
            check($sformatf("vec%0d x", i), s_nx, vecs[i].ex);
            check($sformatf("vec%0d y", i), s_ny, vecs[i].ey);
            check($sformatf("vec%0d vx", i), s_nvx, vecs[i].evx);
            check($sformatf("vec%0d vy", i), s_nvy, vecs[i].evy);
            check($sformatf("vec%0d landed", i), s_land, vecs[i].eland);
            if (vecs[i].eland != 0)
                check($sformatf("vec%0d side", i), s_side, vecs[i].eside);
        end

        // Serve left and free fall for 8 ticks, then a full-strength hit
        cyc();
        serve = 1'b1; serve_side = 1'b0;
        cyc();
        serve = 1'b0;
        check("serve in_play", in_play, 1);
        check("serve y", ball_pos_y, 100);
        ticks(8);
        check("fall8 vy", ball_v_y, 16);
        check("fall8 y", ball_pos_y, 106);
        check("fall8 x", ball_pos_x, 120);
        hit_if.hit_valid = 1'b1; hit_if.hit_v_x = 10'sd200; hit_if.hit_v_y = -10'sd200;
        cyc();
        hit_if.hit_valid = 1'b0;
        check("hit vx", ball_v_x, 200);
        check("hit vy", ball_v_y, -200);
        ticks(1);
        check("post-hit vy", ball_v_y, -198);
        check("post-hit x", ball_pos_x, 145);
        check("post-hit y", ball_pos_y, 81);

        // Held hit with a tick every other cycle: captures at cycle 0 and 17
        reset_dut();
        serve = 1'b1; serve_side = 1'b0;
        cyc();
        serve = 1'b0;
        prev_vx = ball_v_x; ncap = 0; cap0 = -1; cap1 = -1;
        for (int t = 0; t <= 30; t++) begin
            hit_if.hit_valid = 1'b1;
            hit_if.hit_v_x   = 10'(1 + t);
            hit_if.hit_v_y   = -10'sd40;
            tick = (t % 2 == 0);
            cyc();
            if (t == 0) begin
                check("hit+tick y held", ball_pos_y, 100);
                check("hit+tick x held", ball_pos_x, 120);
            end
            if (int'(ball_v_x) != prev_vx) begin
                if (ncap == 0) cap0 = t;
                else if (ncap == 1) cap1 = t;
                ncap++;
                prev_vx = ball_v_x;
            end
        end
        hit_if.hit_valid = 1'b0;
        tick = 1'b0;
        check("held hit captures", ncap, 2);
        check("first capture cycle", cap0, 0);
        check("second capture cycle", cap1, 17);

        // Serve right, fall to the ground, then the landing hold
        reset_dut();
        serve = 1'b1; serve_side = 1'b1;
        cyc();
        serve = 1'b0;
        check("serve right x", ball_pos_x, 520);
        found = 0;
        tick = 1'b1;
        for (int k = 0; k < 300; k++) begin
            cyc();
            if (land_pulse) begin
                found = 1;
                break;
            end
        end
        tick = 1'b0;
        check("landing seen", found, 1);
        check("land y", ball_pos_y, 440);
        check("land x", ball_pos_x, 520);
        check("land vx", ball_v_x, 0);
        check("land vy", ball_v_y, 0);
        check("land side", land_side, 1);
        check("land in_play", in_play, 0);
        cyc();
        check("land pulse width", land_pulse, 0);
        check("land side held", land_side, 1);
        ticks(59);
        serve = 1'b1; serve_side = 1'b0;
        cyc();
        serve = 1'b0;
        check("early serve in_play", in_play, 0);
        check("early serve y", ball_pos_y, 440);
        ticks(1);
        check("hold done in_play", in_play, 0);
        serve = 1'b1;
        cyc();
        serve = 1'b0;
        check("reserve in_play", in_play, 1);
        check("reserve x", ball_pos_x, 120);
        check("reserve y", ball_pos_y, 100);

        // Saturated hit, a few ticks, then asynchronous reset between edges
        ticks(5);
        hit_if.hit_valid = 1'b1; hit_if.hit_v_x = 10'sd300; hit_if.hit_v_y = -10'sd300;
        cyc();
        hit_if.hit_valid = 1'b0;
        check("sat hit vx", ball_v_x, 200);
        check("sat hit vy", ball_v_y, -200);
        ticks(3);
        check("pre-reset x", ball_pos_x, 195);
        check("pre-reset y", ball_pos_y, 27);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async reset");
        #2;
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
